// File: rtl/serial_word_rx.sv
// serial_word_rx: LSB-first serial-to-parallel word receiver with a small
// first-word-fall-through output FIFO behind a valid/ready port.
//   - Frames of WIDTH data bits, each bit qualified by sin_vld.
//   - sync aborts a partial frame; FIFO contents and ovf are kept.
//   - ovf is sticky once a completed word is dropped on a full FIFO.
// Optional feature, enabled by defining PARITY_CHECK_EN:
//   an even-parity bit follows the data bits; par_err pulses for one cycle
//   when a word failing parity is pushed (the word is still pushed).
//   Without the macro, frames are WIDTH bits and par_err is tied low.
module serial_word_rx #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sin,
  input  logic                       sin_vld,
  input  logic                       sync,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_vld,
  input  logic                       dout_rdy,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       ovf,
  output logic                       par_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = $clog2(DEPTH);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  // ---------------------------------------------------------------------------
  // Deserializer
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] shifted;
  logic             push;
  logic [WIDTH-1:0] push_word;
`ifdef PARITY_CHECK_EN
  logic             perr_d;
  logic             perr_q;
`endif

  // New bit enters at the MSB; after WIDTH bits the first one sits in bit 0.
  assign shifted = WIDTH'({sin, shreg_q} >> 1);

  // Next-state, shift-register and push decode for the frame FSM.
  // NOTE: every signal gets a default at the top of the always_comb so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = bit_cnt;
    push      = 1'b0;
    push_word = shifted;
`ifdef PARITY_CHECK_EN
    perr_d    = 1'b0;
`endif
    if (sync) begin
      // Abort wins over any bit presented in the same cycle.
      state_d = IDLE;
      shreg_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // bit_cnt may still show WIDTH for the cycle after completion.
          cnt_d = '0;
          if (sin_vld) begin
            shreg_d = shifted;
            cnt_d   = CW'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (sin_vld) begin
            shreg_d = shifted;
            cnt_d   = bit_cnt + CW'(1);
            if (bit_cnt == CW'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
              // Data complete; hold the word until its parity bit arrives.
              state_d = PARITY;
`else
              state_d   = IDLE;
              shreg_d   = '0;
              push      = 1'b1;
              push_word = shifted;
`endif
            end
          end
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          if (sin_vld) begin
            state_d   = IDLE;
            shreg_d   = '0;
            cnt_d     = '0;
            push      = 1'b1;
            push_word = shreg_q;
            perr_d    = ^{shreg_q, sin};
          end
        end
`endif
        default: begin
          state_d = IDLE;
          shreg_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Frame state register.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_cnt <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_cnt <= cnt_d;
    end
  end

`ifdef PARITY_CHECK_EN
  // One-cycle parity error pulse, aligned with the push edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perr_q <= 1'b0;
    else     perr_q <= perr_d;
  end
  assign par_err = perr_q;
`else
  assign par_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Output FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, pop, push_ok;

  assign full     = (count == (AW + 1)'(DEPTH));
  assign dout_vld = (count != '0);
  assign pop      = dout_vld & dout_rdy;
  // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
  assign push_ok  = push & (~full | pop);
  // Empty FIFO presents zero rather than stale storage.
  assign dout     = dout_vld ? mem[rd_ptr] : '0;

  // Pointer, occupancy and overflow bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
      if (push && !push_ok) ovf <= 1'b1;
    end
  end

  // Storage write.
  // NOTE: the storage array has no reset; occupancy is reset instead, and
  // dout is gated by dout_vld, so stale entries are never observable.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

endmodule
